// File: rtl/ds_frame_ctrl.sv
// Frame sequencer for the downscale datapath: walks the frame buffer with credit-throttled reads
// and buffers downscaler output in a small FIFO. DS_FRAME_STATS_EN adds per-frame pop statistics.
module ds_frame_ctrl #(
    parameter int SRC_PIX    = 65536,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int SCL_LAT    = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int EXP_OUT    = 9216
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              scl_rst_n,
    input  logic              scl_wr_en,
    input  logic [DATA_W-1:0] scl_pix,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef DS_FRAME_STATS_EN
    ,
    output logic [15:0]       out_cnt,
    output logic              cnt_err
`endif
);

    localparam int LAT   = RD_LAT + SCL_LAT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = $clog2(FIFO_DEPTH + LAT + 1) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SRC_PIX - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || EXP_OUT < 0) begin : g_bad_cfg
        $error("ds_frame_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and EXP_OUT non-negative");
    end

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT-1:0]    infl_q, infl_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [SUM_W-1:0]  inflight;
    logic              issue, push, pop;

    // Every read in the pipe may still turn into a pixel, so reserve a FIFO slot for each.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + SUM_W'(infl_q[i]);
    end

    assign issue     = (state_q == S_RUN) && ((SUM_W'(cnt_q) + inflight) < SUM_W'(FIFO_DEPTH));
    assign push      = scl_wr_en && (state_q == S_RUN || state_q == S_DRAIN);
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        infl_d[0] = issue;
        for (int i = 1; i < LAT; i++) infl_d[i] = infl_q[i-1];
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR: begin
                addr_d   = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) state_d = S_DRAIN;
                    else                     addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: if (inflight == '0 && cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            infl_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            infl_q   <= infl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= scl_pix;
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign busy      = (state_q == S_CLR) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign scl_rst_n = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bram_en   = issue;
    assign bram_addr = addr_q;

`ifdef DS_FRAME_STATS_EN
    logic [15:0] out_cnt_q, out_cnt_d;
    logic        cnt_err_q, cnt_err_d;

    always_comb begin
        out_cnt_d = out_cnt_q;
        cnt_err_d = cnt_err_q;
        if (state_q == S_CLR) begin
            out_cnt_d = '0;
            cnt_err_d = 1'b0;
        end else if (pop && out_cnt_q != 16'hFFFF) begin
            out_cnt_d = out_cnt_q + 16'd1;
        end
        if (state_q == S_DONE && out_cnt_q != 16'(EXP_OUT)) cnt_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q <= '0;
            cnt_err_q <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign out_cnt = out_cnt_q;
    assign cnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_ds_frame_ctrl.sv
// Scoreboard bench for ds_frame_ctrl: BRAM + downscaler models feed the DUT; a reference list of
// expected pixels is built per frame from address arithmetic and popped by an output monitor.
module tb_ds_frame_ctrl;
    localparam int SRC_PIX    = 512;
    localparam int COLS       = 32;
    localparam int ADDR_W     = 17;
    localparam int FIFO_DEPTH = 8;
    localparam int EXP_OUT    = 72;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, bram_en, scl_rst_n, out_valid;
    logic [ADDR_W-1:0] bram_addr;
    logic              scl_wr_en = 1'b0;
    logic [15:0]       scl_pix = '0;
    logic [15:0]       out_data;
    logic              out_ready = 1'b0;
`ifdef DS_FRAME_STATS_EN
    logic [15:0]       out_cnt;
    logic              cnt_err;
`endif

    ds_frame_ctrl #(
        .SRC_PIX(SRC_PIX), .ADDR_W(ADDR_W), .DATA_W(16), .RD_LAT(1), .SCL_LAT(1),
        .FIFO_DEPTH(FIFO_DEPTH), .EXP_OUT(EXP_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .bram_addr(bram_addr), .bram_en(bram_en), .scl_rst_n(scl_rst_n),
        .scl_wr_en(scl_wr_en), .scl_pix(scl_pix),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef DS_FRAME_STATS_EN
        , .out_cnt(out_cnt), .cnt_err(cnt_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_addr = 0;
    int          done_cnt = 0;
    int          occ = 0;
    int          rmode = 0;
    logic [15:0] exp_q[$];

    function automatic bit kc(input int v);
        return (v == 0) || (v == 3) || (v == 5);
    endfunction
    // 3-of-8 decimation in both dimensions, like 256->96
    function automatic bit keep(input int i);
        return kc((i % COLS) % 8) && kc((i / COLS) % 8);
    endfunction
    function automatic logic [15:0] pix(input int a);
        int v;
        v = (a * 40503) ^ 32'h1357;
        return v[15:0];
    endfunction
    function automatic logic [15:0] scl_f(input logic [15:0] p);
        return {p[4:0], p[15:5]} ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame buffer (1-cycle read) and downscaler (1-cycle, enabled by the delayed read strobe)
    logic [15:0] rd_data = '0;
    logic        en_d1 = 1'b0;
    int          sidx = 0;
    always @(posedge clk) begin
        en_d1 <= bram_en;
        if (bram_en) rd_data <= pix(int'(bram_addr));
    end
    always @(posedge clk) begin
        if (!scl_rst_n) begin
            sidx      <= 0;
            scl_wr_en <= 1'b0;
        end else begin
            scl_wr_en <= en_d1 && keep(sidx);
            if (en_d1) begin
                scl_pix <= scl_f(rd_data);
                sidx    <= sidx + 1;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 3);
            default: out_ready = 1'b0;
        endcase
    end

    // Output / address monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pixel: got 0x%0h expected none (queue empty) at %0t", out_data, $time);
                end else begin
                    chk("pixel", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (bram_en) begin
                chk("addr", 32'(bram_addr), 32'(exp_addr));
                exp_addr++;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            occ = occ + int'(scl_wr_en && scl_rst_n) - int'(out_valid && out_ready);
            if (occ > FIFO_DEPTH) chk("fifo_occ_bound", 32'(occ), 32'(FIFO_DEPTH));
        end
    end

    // mode: 0 ready=1, 1 random 30%, 2 ready held low, 3 start while busy, 4 reset mid-frame
    task automatic run_frame(input int mode, input int at);
        int                cyc;
        int                kept;
        bit                evt;
        logic [ADDR_W-1:0] a0;
        exp_q.delete();
        kept = 0;
        for (int a = 0; a < SRC_PIX; a++)
            if (keep(a)) begin exp_q.push_back(scl_f(pix(a))); kept++; end
        exp_addr = 0; done_cnt = 0; evt = 0;
        rmode = (mode == 1) ? 1 : 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_scl_rst_n", 32'(scl_rst_n), 32'd0);
        @(posedge clk); #1;
        chk("run_scl_rst_n", 32'(scl_rst_n), 32'd1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            if (!evt && mode >= 2 && exp_addr >= at) begin
                evt = 1;
                if (mode == 2) begin
                    rmode = 2;
                    repeat (500) @(posedge clk);
                    #1 a0 = bram_addr;
                    repeat (500) @(posedge clk);
                    #1;
                    chk("hold_bram_en", 32'(bram_en), 32'd0);
                    chk("hold_addr_frozen", 32'(bram_addr), 32'(a0));
                    chk("hold_fifo_full", 32'(occ), 32'(FIFO_DEPTH));
                    chk("hold_out_valid", 32'(out_valid), 32'd1);
                    rmode = 0;
                end else if (mode == 3) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("start_ignored_busy", 32'(busy), 32'd1);
                end else begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_out_valid", 32'(out_valid), 32'd0);
                    chk("rst_en_scl", {30'd0, bram_en, scl_rst_n}, 32'd0);
                    chk("rst_addr", 32'(bram_addr), 32'd0);
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                    exp_q.delete();
                    chk("rst_no_done", 32'(done_cnt), 32'd0);
                    return;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("frame_done", 32'(done), 32'd1);
        if (done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("start_at_done_ignored", 32'(busy), 32'd0);
            chk("reads_issued", 32'(exp_addr), 32'(SRC_PIX));
            chk("pixels_left", 32'(exp_q.size()), 32'd0);
            chk("done_pulses", 32'(done_cnt), 32'd1);
`ifdef DS_FRAME_STATS_EN
            chk("out_cnt", 32'(out_cnt), 32'(kept));
            chk("cnt_err", 32'(cnt_err), 32'd0);
`endif
        end
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, busy, done, bram_en, scl_rst_n, out_valid, 1'b0}, 32'd0);
        chk("reset_addr", 32'(bram_addr), 32'd0);
        rst_n = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            chk("idle_outputs", {27'd0, busy, done, bram_en, scl_rst_n, out_valid}, 32'd0);
        end
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 200);
        run_frame(3, 300);
        run_frame(4, 400);
        chk("post_rst_idle", {30'd0, busy, out_valid}, 32'd0);
        run_frame(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ds_frame_ctrl.md
Name: ds_frame_ctrl

Overview:
Frame sequencer for the downscale datapath: BRAM frame buffer -> RGB separate -> per-channel downscaler -> RGB compress.
- On a start pulse it walks the source frame buffer address space, drives the read port, and gives the per-channel downscalers a clean per-frame reset.
- It collects downscaler output pixels into an internal FIFO that the sink drains with valid/ready.
- It throttles BRAM reads with credits so that no output pixel is lost under sink backpressure.

Parameters:
- SRC_PIX, 65536, source pixels per frame (256x256).
- ADDR_W, 17, BRAM address width.
- DATA_W, 16, RGB565 pixel width.
- RD_LAT, 1, BRAM read latency in cycles.
- SCL_LAT, 1, downscaler latency from din to dout/write_en.
- FIFO_DEPTH, 8, output FIFO depth; power of 2, >= 2.
- EXP_OUT, 9216, expected output pixels per frame (96x96). Used only with the optional feature.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle frame start request; ignored unless idle.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse at frame completion.
- bram_addr, out, ADDR_W, frame buffer read address.
- bram_en, out, 1, read issued this cycle.
- scl_rst_n, out, 1, synchronous active-low reset to the downscalers.
- scl_wr_en, in, 1, downscaler output valid (write_en).
- scl_pix, in, DATA_W, compressed RGB565 downscaler output.
- out_valid, out, 1, FIFO head valid.
- out_data, out, DATA_W, FIFO head pixel.
- out_ready, in, 1, sink accepts the head.

Behaviour:
- Reset values: busy=0, done=0, bram_addr=0, bram_en=0, scl_rst_n=0, out_valid=0, FIFO empty, state=IDLE.
- State machine:
  - IDLE: scl_rst_n=0. start -> CLR.
  - CLR: exactly 1 cycle. scl_rst_n=0, busy=1, addr counter=0, FIFO flushed -> RUN.
  - RUN: scl_rst_n=1. Issue reads while allowed; after the read of address SRC_PIX-1 is issued -> DRAIN.
  - DRAIN: no reads. When in-flight count=0 and FIFO empty -> DONE.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE. busy drops in the same cycle done rises.
- In-flight tracking: a shift register of length RD_LAT+SCL_LAT carries bram_en. inflight = popcount of that register.
- Issue rule: bram_en=1 only in RUN when fifo_count + inflight < FIFO_DEPTH. This is a worst-case credit, since the downscaler emits at most one pixel per input. The FIFO therefore never overflows.
- Address counter:
  - Increments by 1 per issued read; bram_addr is registered and is valid in the same cycle bram_en=1.
  - Stops at SRC_PIX-1; the counter never wraps within a frame.
  - bram_addr holds its last value when idle.
- Downscaler feed ordering: the downscalers see one new source pixel per issued read, strictly in address order. When bram_en=0 the datapath input is held, so stalls must not advance the downscalers. Every scaler input cycle therefore corresponds to bram_en delayed by RD_LAT, and the integration gates the scaler clock-enable with that delayed strobe.
- FIFO:
  - Push when scl_wr_en=1 and state is RUN or DRAIN.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop is allowed at any occupancy.
  - Push while full is impossible by construction.
  - out_data is stable while out_valid=1 and out_ready=0.
- start while busy: ignored, no restart.
- Reset mid-frame: everything returns to reset values immediately, FIFO contents are discarded, and no done pulse is issued.
- Back-to-back frames: start in the same cycle as done is ignored. start one cycle after done is accepted.

Optional Feature:
- Macro DS_FRAME_STATS_EN.
- Defined:
  - Adds output port out_cnt (16-bit): pixels popped this frame, cleared in CLR, saturating at 16'hFFFF.
  - Adds output port cnt_err (1-bit): set in DONE if out_cnt != EXP_OUT, cleared on the next CLR or reset.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle, with start never asserted: busy=0, bram_en=0, scl_rst_n=0, out_valid=0 for 100 cycles.
- Full frame, out_ready=1 always: bram_addr goes 0x00000..0x0FFFF exactly once each, in order. 9216 pixels come out matching the golden 96x96 file. One done pulse. Total RUN cycles = 65536 plus any credit stalls.
- Random out_ready at 30% duty: same 9216 pixels in the same order as the previous scenario. fifo_count never exceeds 8; bram_en drops whenever fifo_count+inflight=8.
- out_ready=0 held for 1000 cycles mid-frame: FIFO fills to 8, bram_en stays 0, and bram_addr is frozen. On release the frame resumes with no lost or duplicated pixel.
- start pulse at frame pixel 30000: ignored, addresses continue without restart.
- rst_n low at pixel 40000, then new start: busy=0 and FIFO empty immediately. The new frame begins at addr 0 with scl_rst_n low for exactly one cycle, and its output matches golden. With DS_FRAME_STATS_EN defined: out_cnt=9216, cnt_err=0.
